// File: rtl/stp_pkg.sv
// Shared types and helpers for the serial-to-parallel frame receiver.
// Holds the receive FSM encoding, counter sizing helper and idle line level.
package stp_pkg;

  typedef enum logic {
    IDLE,
    RECV
  } rx_state_t;

  localparam logic IDLE_LEVEL = 1'b1;

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/flex_stp_sr.sv
// Flexible serial-to-parallel shift register, idle level on reset/clear.
// Ports: clk, n_rst, shift_enable, clear, serial_in -> parallel_out.
module flex_stp_sr
  import stp_pkg::*;
#(
  parameter int NUM_BITS  = 9,
  parameter bit SHIFT_MSB = 1'b1
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                shift_enable,
  input  logic                clear,
  input  logic                serial_in,
  output logic [NUM_BITS-1:0] parallel_out
);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      parallel_out <= {NUM_BITS{IDLE_LEVEL}};
    end else if (clear) begin
      parallel_out <= {NUM_BITS{IDLE_LEVEL}};
    end else if (shift_enable) begin
      if (SHIFT_MSB)
        parallel_out <= {parallel_out[NUM_BITS-2:0], serial_in};
      else
        parallel_out <= {serial_in, parallel_out[NUM_BITS-1:1]};
    end
  end

endmodule

// File: rtl/stp_frame_rcvr.sv
// Serial frame receiver: bit counter, FSM, double-buffered word, handshake.
// Ports: shift_enable/serial_in/frame_start/data_read in; parallel_out,
// data_ready, overrun_error, busy out (+parity_error if STP_PARITY_CHECK_EN).
module stp_frame_rcvr
  import stp_pkg::*;
#(
  parameter int NUM_BITS  = 9,
  parameter bit SHIFT_MSB = 1'b1
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                shift_enable,
  input  logic                serial_in,
  input  logic                frame_start,
  input  logic                data_read,
  output logic [NUM_BITS-1:0] parallel_out,
  output logic                data_ready,
  output logic                overrun_error,
  output logic                busy
`ifdef STP_PARITY_CHECK_EN
  ,
  output logic                parity_error
`endif
);

`ifdef STP_PARITY_CHECK_EN
  localparam int FRAME_LEN = NUM_BITS + 1;
`else
  localparam int FRAME_LEN = NUM_BITS;
`endif
  localparam int CW = cnt_width(NUM_BITS);
  localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);

  rx_state_t     state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          done;
  logic          sr_en;
  logic [NUM_BITS-1:0] sreg, word;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    done    = 1'b0;
    unique case (state)
      IDLE: begin
        if (shift_enable && !frame_start) begin
          state_n = RECV;
          cnt_n   = CW'(1);
        end
      end
      RECV: begin
        if (frame_start) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (shift_enable) begin
          if (cnt == LAST) begin
            done    = 1'b1;
            state_n = IDLE;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  assign busy = (cnt != '0);

`ifdef STP_PARITY_CHECK_EN
  // Trailing parity bit never enters the data register.
  assign sr_en = shift_enable && !frame_start && (cnt != LAST);
  assign word  = sreg;
`else
  assign sr_en = shift_enable && !frame_start;
  // Word including the bit being sampled on the completing edge.
  assign word  = SHIFT_MSB ? {sreg[NUM_BITS-2:0], serial_in}
                           : {serial_in, sreg[NUM_BITS-1:1]};
`endif

  flex_stp_sr #(
    .NUM_BITS (NUM_BITS),
    .SHIFT_MSB(SHIFT_MSB)
  ) u_sr (
    .clk         (clk),
    .n_rst       (n_rst),
    .shift_enable(sr_en),
    .clear       (frame_start),
    .serial_in   (serial_in),
    .parallel_out(sreg)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      parallel_out  <= {NUM_BITS{IDLE_LEVEL}};
      data_ready    <= 1'b0;
      overrun_error <= 1'b0;
    end else if (done) begin
      parallel_out <= word;
      data_ready   <= 1'b1;
      if (data_ready && !data_read)
        overrun_error <= 1'b1;
      else if (data_read)
        overrun_error <= 1'b0;
    end else if (data_read) begin
      data_ready    <= 1'b0;
      overrun_error <= 1'b0;
    end
  end

`ifdef STP_PARITY_CHECK_EN
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)
      parity_error <= 1'b0;
    else if (done)
      parity_error <= (^sreg) ^ serial_in;
  end
`endif

endmodule
